multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main sequencing FSM for the multi-cycle RV32I datapath.
- Decodes opcode; drives PC/IR/register-file/memory enables, mux selects, and the 2-bit alu_op consumed by the ALU control decoder.
- Handles variable-latency memory via a ready handshake with watchdog; counts retired instructions; traps on illegal opcode or memory timeout.

Parameters:
MEM_TIMEOUT, 255, max consecutive wait cycles for mem_ready before trap; 0 disables watchdog
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  load PC
ir_write  out  1  load IR
i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
mem_to_reg  out  1  writeback select: 0 ALUOut, 1 MDR
alu_src_a  out  1  0 PC, 1 rs1
alu_src_b  out  2  00 rs2, 01 const 4, 10 imm, 11 branch offset
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
pc_src  out  1  0 ALU result, 1 ALUOut
state  out  4  current state encoding (debug)
trap  out  1  core trapped
trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none
instret  out  INSTRET_W  retired instruction count

Behaviour:
- Registered state; Moore outputs except pc_write/ir_write in FETCH and pc_write in BRANCH (see below). Unlisted outputs 0 in each state.
- Encoding: RESET 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, ALU_WB 8, BRANCH 9, TRAP 15.
- rst_n low (any time, mid-access included): state=RESET, all outputs 0, instret=0, trap_cause=00, wait counter=0. RESET -> FETCH unconditionally next cycle.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready. mem_ready=1 -> DECODE, else hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next by opcode: 0000011/0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 1100011 -> BRANCH; other -> TRAP, cause 01.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Load -> MEM_RD, store -> MEM_WR (opcode held stable by IR).
- MEM_RD: mem_read=1, i_or_d=1; mem_ready -> MEM_WB, else hold.
- MEM_WB: reg_write=1, mem_to_reg=1; -> FETCH, retire.
- MEM_WR: mem_write=1, i_or_d=1; mem_ready -> FETCH with retire, else hold.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0; -> FETCH, retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero; -> FETCH, retire regardless of zero.
- Retire: instret+1 on the transition cycle; wraps modulo 2^INSTRET_W.
- Watchdog: counter cleared on entry to FETCH/MEM_RD/MEM_WR and whenever mem_ready=1; increments each waiting cycle with mem_ready=0. When count reaches MEM_TIMEOUT (nonzero) -> TRAP, cause 10; request deasserts in TRAP.
- TRAP: trap=1, trap_cause held, all control outputs 0, instret frozen; exit only via rst_n.
- Nominal latency with mem_ready=1: R 4, LW 5, SW 4, BEQ 3 cycles.

Test Plan:
- Reset release, mem_ready=1, R-type opcode 0110011 -> states 0,1,2,7,8,1; reg_write=1, alu_op=10 only in EXEC_R; instret=1.
- LW 0000011 with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_read=1, i_or_d=1 throughout; then MEM_WB mem_to_reg=1; instret+1.
- BEQ with zero=1 then zero=0 -> pc_write=1 then 0 in BRANCH, pc_src=1, alu_op=01; instret increments both times.
- Opcode 1111111 at DECODE -> TRAP (15), trap=1, cause 01, outputs 0 for 20 cycles; rst_n pulse -> RESET, cause 00.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 waiting cycles, cause 10, mem_read drops.
- rst_n asserted mid-MEM_WR -> outputs 0 immediately (async), instret=0, restart at FETCH after release.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main sequencing FSM for the multi-cycle RV32I datapath
`timescale 1ns/1ps
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 pc_src,
    output logic [3:0]           state,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret
);
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam int unsigned WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t               state_q, state_d;
    logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic [1:0]           cause_q, cause_d;
    logic                 retire;
    logic                 waiting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            wd_cnt_q  <= '0;
            instret_q <= '0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            wd_cnt_q  <= wd_cnt_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        wd_cnt_d   = '0;
        retire     = 1'b0;
        waiting    = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 1'b0;
        trap       = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                waiting   = 1'b1;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                waiting  = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                waiting   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = zero;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP: trap = 1'b1;
            default: state_d = S_RESET;
        endcase

        // Leaving a wait state always coincides with mem_ready=1, so the
        // counter is naturally zero on every entry to FETCH/MEM_RD/MEM_WR.
        if (waiting && !mem_ready) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
            if ((MEM_TIMEOUT != 0) && (wd_cnt_d == WD_W'(MEM_TIMEOUT))) begin
                state_d = S_TRAP;
                cause_d = 2'b10;
            end
        end

        instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
    end

    assign state      = state_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - trace-model bench for multicycle_control
`timescale 1ns/1ps
module tb_multicycle_control;
    localparam int TO = 4;
    localparam int IW = 4;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [3:0] ST_RESET = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MADDR = 4'd3;
    localparam logic [3:0] ST_MRD = 4'd4, ST_MWB = 4'd5, ST_MWR = 4'd6, ST_EXEC = 4'd7;
    localparam logic [3:0] ST_AWB = 4'd8, ST_BR = 4'd9, ST_TRAP = 4'd15;

    logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a, pc_src, trap;
    logic [1:0] alu_src_b, alu_op, trap_cause;
    logic [3:0] state;
    logic [IW-1:0] instret;
    logic [12:0] ctl_act;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(TO), .INSTRET_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    assign ctl_act = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                      mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

    typedef struct {
        logic [3:0]    st;
        logic [6:0]    op;
        logic          z;
        logic          rdy;
        logic          rst;
        logic [IW-1:0] ir;
        logic [1:0]    cause;
    } step_t;

    step_t q[$];
    step_t cur;
    bit cmp_en = 0;
    int checks = 0, errors = 0;
    int m_ir = 0;
    logic [1:0] m_cause = 2'b00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [3:0] st, input logic [6:0] op, input logic z,
                                 input logic rdy, input logic rst);
        step_t s;
        s.st = st; s.op = op; s.z = z; s.rdy = rdy; s.rst = rst;
        s.ir = IW'(m_ir); s.cause = m_cause;
        q.push_back(s);
    endfunction

    function automatic void retire();
        m_ir = (m_ir + 1) % (1 << IW);
    endfunction

    function automatic void go_trap(input logic [1:0] cause, input logic [6:0] op);
        m_cause = cause;
        for (int i = 0; i < 20; i++) push(ST_TRAP, op, 1'b0, i[0], 1'b1);
    endfunction

    function automatic void reset_steps(input int n);
        m_ir = 0;
        m_cause = 2'b00;
        for (int i = 0; i < n; i++) push(ST_RESET, 7'd0, 1'b0, 1'b0, 1'b0);
        push(ST_RESET, 7'd0, 1'b0, 1'b1, 1'b1);
    endfunction

    // One instruction as a cycle trace: fw/mw are mem_ready-low cycles in fetch/memory phase.
    function automatic void issue(input logic [6:0] op, input logic z, input int fw, input int mw, input bit fin);
        logic [3:0] ms;
        int n;
        n = (fw >= TO) ? TO : fw;
        for (int i = 0; i < n; i++) push(ST_FETCH, op, z, 1'b0, 1'b1);
        if (fw >= TO) begin go_trap(2'b10, op); return; end
        push(ST_FETCH, op, z, 1'b1, 1'b1);
        push(ST_DECODE, op, z, 1'b1, 1'b1);
        case (op)
            LD, ST: begin
                ms = (op == ST) ? ST_MWR : ST_MRD;
                push(ST_MADDR, op, z, 1'b1, 1'b1);
                n = (mw >= TO) ? TO : mw;
                for (int i = 0; i < n; i++) push(ms, op, z, 1'b0, 1'b1);
                if (mw >= TO) begin go_trap(2'b10, op); return; end
                if (!fin) return;
                push(ms, op, z, 1'b1, 1'b1);
                if (op == LD) push(ST_MWB, op, z, 1'b1, 1'b1);
                retire();
            end
            RT: begin
                push(ST_EXEC, op, z, 1'b1, 1'b1);
                push(ST_AWB, op, z, 1'b1, 1'b1);
                retire();
            end
            BR: begin
                push(ST_BR, op, z, 1'b1, 1'b1);
                retire();
            end
            default: go_trap(2'b01, op);
        endcase
    endfunction

    function automatic logic [12:0] exp_ctl(input step_t s);
        logic pcw, irw, iod, mr, mwr, rw, mtr, asa, pcs;
        logic [1:0] asb, aop;
        {pcw, irw, iod, mr, mwr, rw, mtr, asa, pcs} = '0;
        asb = 2'b00; aop = 2'b00;
        case (s.st)
            ST_FETCH:  begin mr = 1; asb = 2'b01; pcw = s.rdy; irw = s.rdy; end
            ST_DECODE: asb = 2'b11;
            ST_MADDR:  begin asa = 1; asb = 2'b10; end
            ST_MRD:    begin mr = 1; iod = 1; end
            ST_MWB:    begin rw = 1; mtr = 1; end
            ST_MWR:    begin mwr = 1; iod = 1; end
            ST_EXEC:   begin asa = 1; aop = 2'b10; end
            ST_AWB:    rw = 1;
            ST_BR:     begin asa = 1; aop = 2'b01; pcs = 1; pcw = s.z; end
            default:   ;
        endcase
        return {pcw, irw, iod, mr, mwr, rw, mtr, asa, asb, aop, pcs};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", 32'(state), 32'(cur.st));
            chk("ctl", 32'(ctl_act), 32'(exp_ctl(cur)));
            chk("trap", 32'(trap), 32'(cur.st == ST_TRAP));
            chk("trap_cause", 32'(trap_cause), 32'(cur.cause));
            chk("instret", 32'(instret), 32'(cur.ir));
        end
    end

    task automatic run_queue();
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            cur = q.pop_front();
            rst_n = cur.rst; opcode = cur.op; zero = cur.z; mem_ready = cur.rdy;
            cmp_en = 1;
        end
        @(negedge clk);
        #1;
        cmp_en = 0;
    endtask

    initial begin
        int n0;
        reset_steps(2);
        n0 = q.size(); issue(RT, 1'b0, 0, 0, 1'b1);
        chk("model_lat_r", q.size() - n0, 4);
        chk("model_ir_r", m_ir, 1);
        run_queue();

        n0 = q.size(); issue(LD, 1'b0, 0, 3, 1'b1);
        chk("model_lat_lw_wait3", q.size() - n0, 8);
        n0 = q.size(); issue(ST, 1'b0, 1, 2, 1'b1);
        chk("model_lat_sw_waits", q.size() - n0, 7);
        n0 = q.size(); issue(BR, 1'b1, 0, 0, 1'b1);
        chk("model_lat_beq", q.size() - n0, 3);
        issue(BR, 1'b0, 0, 0, 1'b1);
        issue(LD, 1'b0, 0, 0, 1'b1);
        chk("model_ir_mix", m_ir, 6);
        run_queue();

        for (int i = 0; i < 11; i++) issue(RT, 1'b0, (i == 5) ? 3 : 0, 0, 1'b1);
        chk("model_ir_wrap", m_ir, 1);
        run_queue();

        issue(7'h7f, 1'b0, 0, 0, 1'b1);
        run_queue();
        chk("illegal_state", 32'(state), 15);
        chk("illegal_cause", 32'(trap_cause), 1);
        chk("illegal_trap", 32'(trap), 1);
        reset_steps(2);
        run_queue();
        chk("post_reset_state", 32'(state), 0);
        chk("post_reset_cause", 32'(trap_cause), 0);
        chk("post_reset_instret", 32'(instret), 0);

        issue(RT, 1'b0, 4, 0, 1'b1);
        run_queue();
        chk("fetch_to_cause", 32'(trap_cause), 2);
        chk("fetch_to_mem_read", 32'(mem_read), 0);
        reset_steps(2);
        issue(LD, 1'b0, 0, 5, 1'b1);
        run_queue();
        chk("mrd_to_state", 32'(state), 15);
        chk("mrd_to_cause", 32'(trap_cause), 2);

        reset_steps(2);
        issue(RT, 1'b0, 0, 0, 1'b1);
        issue(ST, 1'b0, 0, 2, 1'b0);
        run_queue();
        chk("pre_async_mem_write", 32'(mem_write), 1);
        chk("pre_async_instret", 32'(instret), 1);
        rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 0);
        chk("async_mem_write", 32'(mem_write), 0);
        chk("async_i_or_d", 32'(i_or_d), 0);
        chk("async_instret", 32'(instret), 0);
        reset_steps(2);
        issue(RT, 1'b0, 0, 0, 1'b1);
        issue(BR, 1'b1, 0, 0, 1'b1);
        run_queue();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
